// File: rtl/leaf_pkg.sv
// Shared field layout and packet construction for the leaf egress/ingress paths.
// Packet layout, MSB first: valid, dest leaf, dest port, sequence address, payload.
package leaf_pkg;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int ADDR_LSB = PAYLOAD_BITS;
    localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

    localparam int DEF_NUM_OUT_PORTS         = 7;
    localparam int DEF_CREDIT_BITS           = 8;
    localparam int DEF_CREDIT_INIT           = 128;
    localparam int DEF_FREESPACE_UPDATE_SIZE = 64;

    typedef logic [PACKET_BITS-1:0] packet_t;

    function automatic packet_t pack_pkt(input logic [NUM_LEAF_BITS-1:0] leaf,
                                         input logic [NUM_PORT_BITS-1:0] port,
                                         input logic [NUM_ADDR_BITS-1:0] addr,
                                         input logic [PAYLOAD_BITS-1:0]  data);
        packet_t p;
        p                              = '0;
        p[PACKET_BITS-1]               = 1'b1;
        p[LEAF_LSB +: NUM_LEAF_BITS]   = leaf;
        p[PORT_LSB +: NUM_PORT_BITS]   = port;
        p[ADDR_LSB +: NUM_ADDR_BITS]   = addr;
        p[0 +: PAYLOAD_BITS]           = data;
        return p;
    endfunction
endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Round-robin priority rotation: first requester after rr_i (wrapping) wins.
// Grants nothing while advance_i is low, so the caller can stall it.
module rr_arbiter #(
    parameter int N  = 7,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);
    logic          found;
    logic [IW-1:0] idx;
    int            pos;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = rr_i;
        found     = 1'b0;
        idx       = '0;
        pos       = 0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(rr_i) + k;
            if (pos >= N) pos = pos - N;
            idx = IW'(pos);
            if (!found && advance_i && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end
endmodule

// File: rtl/leaf_out_arbiter.sv
// Egress stage: round-robin serialises credit-gated user streams into one BFT
// packet stream through a single holding register, with resend freeze.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = DEF_NUM_OUT_PORTS,
    parameter int CREDIT_BITS           = DEF_CREDIT_BITS,
    parameter int CREDIT_INIT           = DEF_CREDIT_INIT,
    parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0]  dest_leaf,
    input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0]  dest_port,
    input  logic                                    credit_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_port,
    input  logic                                    resend,
    input  logic                                    pkt_rdy,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);
    localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int SUM_W = CREDIT_BITS + 2;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

    logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   credit_q, credit_d;
    logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]                            rr_q, rr_d;
    packet_t                                     hold_q, hold_d;

    logic [NUM_OUT_PORTS-1:0] elig, gnt;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     advance, accept;
    logic [NUM_LEAF_BITS-1:0] sel_leaf;
    logic [NUM_PORT_BITS-1:0] sel_port;
    logic [NUM_ADDR_BITS-1:0] sel_addr;
    logic [PAYLOAD_BITS-1:0]  sel_data;
    logic [SUM_W-1:0]         sum;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++)
            elig[i] = vld_user2interface[i] && (credit_q[i] != '0);
    end

    // The holding register's valid bit doubles as the "full" flag.
    assign advance = reset_n && !resend && (!hold_q[PACKET_BITS-1] || pkt_rdy);

    rr_arbiter #(.N(NUM_OUT_PORTS), .IW(IDX_W)) u_rr (
        .req_i     (elig),
        .rr_i      (rr_q),
        .advance_i (advance),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign accept                  = |gnt;
    assign ack_interface2user      = gnt;
    assign dout_leaf_interface2bft = resend ? '0 : hold_q;

    always_comb begin
        sel_leaf = '0;
        sel_port = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt[i]) begin
                sel_leaf = dest_leaf[i*NUM_LEAF_BITS +: NUM_LEAF_BITS];
                sel_port = dest_port[i*NUM_PORT_BITS +: NUM_PORT_BITS];
                sel_addr = addr_q[i];
                sel_data = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_comb begin
        hold_d   = hold_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        credit_d = credit_q;
        sum      = '0;
        if (accept) begin
            hold_d = pack_pkt(sel_leaf, sel_port, sel_addr, sel_data);
            rr_d   = gnt_idx;
        end else if (!resend && pkt_rdy) begin
            hold_d = '0;
        end
        // A send only happens with credit != 0, so the wide sum never underflows.
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(gnt[i]);
            sum = SUM_W'(credit_q[i])
                + ((credit_vld && credit_port == NUM_PORT_BITS'(i)) ? SUM_W'(FREESPACE_UPDATE_SIZE) : '0)
                - SUM_W'(gnt[i]);
            credit_d[i] = (sum > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            rr_q   <= '0;
            addr_q <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++)
                credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
        end else begin
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            credit_q <= credit_d;
        end
    end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: rotation, credits, backpressure, resend, wrap.
module tb_leaf_out_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [223:0] din;
    logic [6:0]   vld, ack;
    logic [34:0]  dleaf;
    logic [27:0]  dport;
    logic         credit_vld;
    logic [3:0]   credit_port;
    logic         resend, pkt_rdy;
    logic [48:0]  dout;

    int n_chk = 0;
    int n_pass = 0;
    int cnt;
    logic [6:0] e;

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dest_leaf               (dleaf),
        .dest_port               (dport),
        .credit_vld              (credit_vld),
        .credit_port             (credit_port),
        .resend                  (resend),
        .pkt_rdy                 (pkt_rdy),
        .dout_leaf_interface2bft (dout)
    );

    function automatic logic [31:0] dat(input int p);
        return (p == 0) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(p);
    endfunction

    function automatic logic [48:0] pkt(input int p, input logic [6:0] a);
        return {1'b1, 5'(p + 3), 4'(p + 2), a, dat(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic rst;
        vld = '0; resend = 0; credit_vld = 0; credit_port = '0; pkt_rdy = 1;
        @(negedge clk); reset_n = 0;
        @(negedge clk); reset_n = 1;
    endtask

    initial begin
        reset_n = 0; vld = '0; credit_vld = 0; credit_port = '0; resend = 0; pkt_rdy = 1;
        for (int p = 0; p < 7; p++) begin
            din[p*32 +: 32] = dat(p);
            dleaf[p*5 +: 5] = 5'(p + 3);
            dport[p*4 +: 4] = 4'(p + 2);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        @(negedge clk); reset_n = 1;

        // single port, latency and address increment
        @(negedge clk); vld = 7'h01; #1;
        chk("t1_ack0", 64'(ack), 64'(7'h01));
        @(negedge clk); #1;
        chk("t1_dout0", 64'(dout), 64'(pkt(0, 7'd0)));
        chk("t1_ack1", 64'(ack), 64'(7'h01));
        @(negedge clk); vld = '0; #1;
        chk("t1_dout1", 64'(dout), 64'(pkt(0, 7'd1)));
        chk("t1_ack_idle", 64'(ack), 64'(0));
        @(negedge clk); #1;
        chk("t1_drain", 64'(dout), 64'(0));

        // all ports valid: strict rotation starting at port 1
        rst();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); vld = 7'h7F; #1;
            e = '0; e[(k + 1) % 7] = 1'b1;
            chk("t2_rot", 64'(ack), 64'(e));
        end
        @(negedge clk); vld = '0; #1;
        chk("t2_dout", 64'(dout), 64'(pkt(0, 7'd1)));

        // credit exhaustion, zero-credit skip, credit return
        rst();
        cnt = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk); vld = 7'h01; #1;
            cnt += int'(ack[0]);
        end
        chk("t3_cnt_init", 64'(cnt), 64'(128));
        chk("t3_starved", 64'(ack), 64'(0));
        @(negedge clk); vld = 7'h03; #1;
        chk("t3_skip_a", 64'(ack), 64'(7'h02));
        @(negedge clk); #1;
        chk("t3_skip_b", 64'(ack), 64'(7'h02));
        @(negedge clk); vld = 7'h01; credit_vld = 1; credit_port = 4'd7; #1;
        chk("t3_oor", 64'(ack), 64'(0));
        @(negedge clk); credit_port = 4'd0; #1;
        chk("t3_ret_same", 64'(ack), 64'(0));
        @(negedge clk); credit_vld = 0; #1;
        chk("t3_resume", 64'(ack), 64'(7'h01));
        cnt = int'(ack[0]);
        for (int k = 0; k < 79; k++) begin
            @(negedge clk); #1;
            cnt += int'(ack[0]);
        end
        chk("t3_cnt_ret", 64'(cnt), 64'(64));

        // backpressure holds the packet, release refills same cycle
        rst();
        @(negedge clk); vld = 7'h7F; pkt_rdy = 0; #1;
        chk("t4_first", 64'(ack), 64'(7'h02));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t4_hold_ack", 64'(ack), 64'(0));
            chk("t4_hold_dout", 64'(dout), 64'(pkt(1, 7'd0)));
        end
        @(negedge clk); pkt_rdy = 1; #1;
        chk("t4_rel_ack", 64'(ack), 64'(7'h04));
        chk("t4_rel_dout", 64'(dout), 64'(pkt(1, 7'd0)));
        @(negedge clk); #1;
        chk("t4_next_dout", 64'(dout), 64'(pkt(2, 7'd0)));
        chk("t4_next_ack", 64'(ack), 64'(7'h08));

        // resend freezes and blanks; held packet survives
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); resend = 1; pkt_rdy = 1; #1;
            chk("t5_rs_dout", 64'(dout), 64'(0));
            chk("t5_rs_ack", 64'(ack), 64'(0));
        end
        @(negedge clk); resend = 0; pkt_rdy = 0; #1;
        chk("t5_back", 64'(dout), 64'(pkt(3, 7'd0)));
        chk("t5_back_ack", 64'(ack), 64'(0));
        @(negedge clk); pkt_rdy = 1; #1;
        chk("t5_rr_kept", 64'(ack), 64'(7'h10));
        @(negedge clk); vld = '0; pkt_rdy = 0; #1;
        chk("t5_p4", 64'(dout), 64'(pkt(4, 7'd0)));
        @(negedge clk); reset_n = 0; #1;
        chk("t5_midrst", 64'(dout), 64'(0));
        @(negedge clk); reset_n = 1; pkt_rdy = 1; #1;
        chk("t5_postrst", 64'(dout), 64'(0));

        // address wrap on port 3 with a mid-stream credit refresh
        rst();
        cnt = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk); vld = 7'h08; credit_vld = (k == 10); credit_port = 4'd3; #1;
            cnt += int'(ack[3]);
            if (k == 128) chk("t6_addr127", 64'(dout), 64'(pkt(3, 7'd127)));
            if (k == 129) chk("t6_addr0", 64'(dout), 64'(pkt(3, 7'd0)));
        end
        @(negedge clk); vld = '0; credit_vld = 0; #1;
        chk("t6_addr1", 64'(dout), 64'(pkt(3, 7'd1)));
        chk("t6_cnt", 64'(cnt), 64'(130));

        // credit saturation: 122 -> 186 -> 250 -> 255
        rst();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); vld = 7'h20; #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); vld = '0; credit_vld = 1; credit_port = 4'd5; #1;
        end
        cnt = 0;
        for (int k = 0; k < 270; k++) begin
            @(negedge clk); vld = 7'h20; credit_vld = 0; #1;
            cnt += int'(ack[5]);
        end
        chk("t7_sat", 64'(cnt), 64'(255));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
